// File: rtl/tmds_deserializer_1_to_10_if.sv
// Parallel-side bundle of the TMDS 1:10 deserializer: DDR bit pair in, aligned character out.
// The master drives the captured bit pair; the slave (deserializer) returns characters and alignment status.
interface tmds_deserializer_1_to_10_if;
  logic       data_rise;
  logic       data_fall;
  logic [9:0] parallel_data;
  logic       data_valid;
  logic       locked;
  logic [3:0] bit_offset;

  modport master (
    output data_rise,
    output data_fall,
    input  parallel_data,
    input  data_valid,
    input  locked,
    input  bit_offset
  );

  modport slave (
    input  data_rise,
    input  data_fall,
    output parallel_data,
    output data_valid,
    output locked,
    output bit_offset
  );
endinterface

// File: rtl/tmds_deserializer_1_to_10.sv
// Rebuilds 10-bit TMDS characters from a DDR serial lane at 5x pixel clock and hunts for word alignment.
// Define TMDS_DESER_ALIGN_EN to compile in the control-token search/lock state machine and bit slip.
module tmds_deserializer_1_to_10 #(
  parameter int unsigned SEARCH_WORDS = 1024,
  parameter int unsigned LOCK_TOKENS  = 8,
  parameter int unsigned LOSS_WORDS   = 4096
) (
  input logic                        serial_clk_5x,
  input logic                        rst,
  tmds_deserializer_1_to_10_if.slave bus
);

  logic [19:0] win;
  logic [19:0] win_next;
  logic [2:0]  phase;
  logic        word_strobe;
  logic [3:0]  offset;
  logic [4:0]  base;
  logic [9:0]  word_next;
  logic [9:0]  data_q;
  logic        valid_q;
  logic        locked_q;
  logic        unused_tail;

  // The pair sampled at this edge is already part of the word being extracted.
  assign win_next    = {bus.data_fall, bus.data_rise, win[19:2]};
  assign word_strobe = (phase == 3'd4);
  assign base        = 5'd10 - {1'b0, offset};
  assign word_next   = win_next[base +: 10];
  assign unused_tail = ^win[1:0];

  always_ff @(posedge serial_clk_5x or posedge rst) begin
    if (rst) begin
      win     <= '0;
      phase   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      win     <= win_next;
      phase   <= word_strobe ? 3'd0 : phase + 3'd1;
      valid_q <= word_strobe;
      if (word_strobe) begin
        data_q <= word_next;
      end
    end
  end

`ifdef TMDS_DESER_ALIGN_EN
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam int unsigned MISS_W = $clog2(SEARCH_WORDS + 1);
  localparam int unsigned HIT_W  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_WORDS + 1);

  state_t            state;
  logic [MISS_W-1:0] miss_cnt;
  logic [HIT_W-1:0]  hit_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic              token_hit;
  logic [3:0]        offset_slip;

  assign token_hit   = word_next inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
  assign offset_slip = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  // Counters clear on reaching their limit, so they can never exceed the parameter value.
  always_ff @(posedge serial_clk_5x or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      miss_cnt <= '0;
      hit_cnt  <= '0;
      loss_cnt <= '0;
      locked_q <= 1'b0;
      offset   <= '0;
    end else if (word_strobe) begin
      unique case (state)
        SEARCH: begin
          if (token_hit) begin
            miss_cnt <= '0;
            hit_cnt  <= HIT_W'(1);
            if (LOCK_TOKENS <= 1) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              loss_cnt <= '0;
            end else begin
              state <= VERIFY;
            end
          end else if (32'(miss_cnt) + 1 >= SEARCH_WORDS) begin
            miss_cnt <= '0;
            offset   <= offset_slip;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (token_hit) begin
            if (32'(hit_cnt) + 1 >= LOCK_TOKENS) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              hit_cnt  <= '0;
              loss_cnt <= '0;
            end else begin
              hit_cnt <= hit_cnt + 1'b1;
            end
          end else begin
            state    <= SEARCH;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            offset   <= offset_slip;
          end
        end
        LOCKED: begin
          if (token_hit) begin
            loss_cnt <= '0;
          end else if (32'(loss_cnt) + 1 >= LOSS_WORDS) begin
            state    <= SEARCH;
            locked_q <= 1'b0;
            loss_cnt <= '0;
            offset   <= offset_slip;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
`else
  logic unused_cfg;

  assign offset     = '0;
  assign unused_cfg = ^{SEARCH_WORDS, LOCK_TOKENS, LOSS_WORDS};

  // Alignment is owned upstream; report lock from the first delivered word.
  always_ff @(posedge serial_clk_5x or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else if (word_strobe) begin
      locked_q <= 1'b1;
    end
  end
`endif

  assign bus.parallel_data = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.locked        = locked_q;
  assign bus.bit_offset    = offset;

endmodule
